// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (req0)
// and the address/branch unit (req1), with a single held response register.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [2:0]       req0_cntrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [2:0]       req1_cntrl,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_negative,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             resp_carry_out,
    output logic             resp_err
);

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_PASS_B, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_is_legal = 1'b1;
            default:                                          op_is_legal = 1'b0;
        endcase
    endfunction

    // Overflow and carry only carry meaning for the arithmetic ops.
    function automatic logic op_is_arith(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: op_is_arith = 1'b1;
            default:        op_is_arith = 1'b0;
        endcase
    endfunction

    logic             can_issue_s;
    logic             grant_valid_s;
    logic             winner_s;
    logic             accept_s;
    logic             last_grant_r;

    logic             cap_err_s;
    logic [WIDTH-1:0] cap_result_s;
    logic             cap_negative_s;
    logic             cap_zero_s;
    logic             cap_overflow_s;
    logic             cap_carry_out_s;

    logic             resp_valid_r;
    logic             resp_id_r;
    logic [WIDTH-1:0] resp_result_r;
    logic             resp_negative_r;
    logic             resp_zero_r;
    logic             resp_overflow_r;
    logic             resp_carry_out_r;
    logic             resp_err_r;

    assign can_issue_s = !resp_valid_r || resp_ready;
    assign accept_s    = grant_valid_s && can_issue_s;

    // Round-robin winner selection; contention favours the side not granted last.
    always_comb begin
        grant_valid_s = 1'b0;
        winner_s      = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            winner_s      = !last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            winner_s      = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            winner_s      = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            winner_s      = 1'b0;
        end
    end

    // Handshake readies and shared ALU operand steering.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_A      = '0;
        alu_B      = '0;
        alu_cntrl  = 3'b000;
        if (grant_valid_s) begin
            req0_ready = can_issue_s && !winner_s;
            req1_ready = can_issue_s && winner_s;
            if (winner_s) begin
                alu_A     = req1_A;
                alu_B     = req1_B;
                alu_cntrl = req1_cntrl;
            end else begin
                alu_A     = req0_A;
                alu_B     = req0_B;
                alu_cntrl = req0_cntrl;
            end
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Response values to capture; illegal ops report a clean zero result.
    always_comb begin
        cap_err_s       = 1'b0;
        cap_result_s    = '0;
        cap_negative_s  = 1'b0;
        cap_zero_s      = 1'b1;
        cap_overflow_s  = 1'b0;
        cap_carry_out_s = 1'b0;
        if (op_is_legal(alu_cntrl)) begin
            cap_result_s   = alu_result;
            cap_negative_s = alu_negative;
            cap_zero_s     = alu_zero;
            if (op_is_arith(alu_cntrl)) begin
                cap_overflow_s  = alu_overflow;
                cap_carry_out_s = alu_carry_out;
            end else begin
                cap_overflow_s  = 1'b0;
                cap_carry_out_s = 1'b0;
            end
        end else begin
            cap_err_s = 1'b1;
        end
    end

    // Response register and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r     <= 1'b1;
            resp_valid_r     <= 1'b0;
            resp_id_r        <= 1'b0;
            resp_result_r    <= '0;
            resp_negative_r  <= 1'b0;
            resp_zero_r      <= 1'b0;
            resp_overflow_r  <= 1'b0;
            resp_carry_out_r <= 1'b0;
            resp_err_r       <= 1'b0;
        end else if (accept_s) begin
            last_grant_r     <= winner_s;
            resp_valid_r     <= 1'b1;
            resp_id_r        <= winner_s;
            resp_result_r    <= cap_result_s;
            resp_negative_r  <= cap_negative_s;
            resp_zero_r      <= cap_zero_s;
            resp_overflow_r  <= cap_overflow_s;
            resp_carry_out_r <= cap_carry_out_s;
            resp_err_r       <= cap_err_s;
        end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

    assign resp_valid     = resp_valid_r;
    assign resp_id        = resp_id_r;
    assign resp_result    = resp_result_r;
    assign resp_negative  = resp_negative_r;
    assign resp_zero      = resp_zero_r;
    assign resp_overflow  = resp_overflow_r;
    assign resp_carry_out = resp_carry_out_r;
    assign resp_err       = resp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]  req0_cntrl, req1_cntrl;
    logic [63:0] alu_A, alu_B, alu_result;
    logic [2:0]  alu_cntrl;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic        resp_valid, resp_ready, resp_id, resp_negative, resp_zero;
    logic        resp_overflow, resp_carry_out, resp_err;
    logic [63:0] resp_result;

    int n_vec = 0;
    int n_err = 0;

    // {valid, id, err, negative, zero, overflow, carry_out, result}
    wire [70:0] resp_bus = {resp_valid, resp_id, resp_err, resp_negative, resp_zero,
                            resp_overflow, resp_carry_out, resp_result};

    alu_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
        .req0_B(req0_B), .req0_cntrl(req0_cntrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
        .req1_B(req1_B), .req1_cntrl(req1_cntrl),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_negative(resp_negative), .resp_zero(resp_zero),
        .resp_overflow(resp_overflow), .resp_carry_out(resp_carry_out), .resp_err(resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural shared ALU; logic ops and illegal codes drive junk flags on purpose.
    always_comb begin
        logic [64:0] t;
        t             = 65'd0;
        alu_overflow  = 1'b1;
        alu_carry_out = 1'b1;
        case (alu_cntrl)
            3'b000: t = {1'b0, alu_B};
            3'b010: begin
                t = {1'b0, alu_A} + {1'b0, alu_B};
                alu_carry_out = t[64];
                alu_overflow  = (alu_A[63] == alu_B[63]) && (t[63] != alu_A[63]);
            end
            3'b011: begin
                t = {1'b0, alu_A} + {1'b0, ~alu_B} + 65'd1;
                alu_carry_out = t[64];
                alu_overflow  = (alu_A[63] != alu_B[63]) && (t[63] != alu_A[63]);
            end
            3'b100: t = {1'b0, alu_A & alu_B};
            3'b101: t = {1'b0, alu_A | alu_B};
            3'b110: t = {1'b0, alu_A ^ alu_B};
            default: t = {1'b0, alu_A ^ 64'hA5A5_A5A5_A5A5_A5A5};
        endcase
        alu_result   = t[63:0];
        alu_negative = t[63];
        alu_zero     = (t[63:0] == 64'd0);
        if (alu_cntrl == 3'b001 || alu_cntrl == 3'b111) begin
            alu_negative = 1'b1;
            alu_zero     = 1'b0;
        end
    end

    // Expected response for an accepted op, from the op-code definitions.
    function automatic logic [70:0] ref_resp(input logic id, input logic [63:0] a,
                                             input logic [63:0] b, input logic [2:0] op);
        logic [64:0] u, s;
        logic [63:0] r;
        logic        ov, cy;
        ov = 1'b0;
        cy = 1'b0;
        r  = 64'd0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                u = {1'b0, a} + {1'b0, b};
                s = {a[63], a} + {b[63], b};
                r = u[63:0]; cy = u[64]; ov = s[64] ^ s[63];
            end
            3'b011: begin
                u = {1'b0, a} + {1'b0, ~b} + 65'd1;
                s = {a[63], a} - {b[63], b};
                r = u[63:0]; cy = u[64]; ov = s[64] ^ s[63];
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: return {1'b1, id, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
        endcase
        return {1'b1, id, 1'b0, r[63], (r == 64'd0), ov, cy, r};
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_A = 64'd0; req0_B = 64'd0; req0_cntrl = 3'b000;
        req1_valid = 1'b0; req1_A = 64'd0; req1_B = 64'd0; req1_cntrl = 3'b000;
        resp_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if (resp_bus !== 71'd0) begin
            n_err++; $display("FAIL reset_resp: got %h want %h", resp_bus, 71'd0);
        end
        n_vec++;
        if ({req0_ready, req1_ready, alu_A, alu_B, alu_cntrl} !== 133'd0) begin
            n_err++; $display("FAIL reset_idle_drive: ready=%b%b alu_A=%h alu_B=%h cntrl=%b want all 0",
                              req0_ready, req1_ready, alu_A, alu_B, alu_cntrl);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_overflow();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 64'h7FFF_FFFF_FFFF_FFFF; req0_B = 64'd1; req0_cntrl = 3'b010;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready, alu_A, alu_cntrl} !== {2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010}) begin
            n_err++; $display("FAIL add_accept: ready=%b%b alu_A=%h cntrl=%b want 10/7fff../010",
                              req0_ready, req1_ready, alu_A, alu_cntrl);
        end
        tick();
        req0_valid = 1'b0;
        n_vec++;
        if (resp_bus !== {7'b1001010, 64'h8000_0000_0000_0000}) begin
            n_err++; $display("FAIL add_resp: got %h want %h", resp_bus,
                              {7'b1001010, 64'h8000_0000_0000_0000});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 64'd5;    req0_B = 64'd5;    req0_cntrl = 3'b011;
        req1_valid = 1'b1; req1_A = 64'hF0;   req1_B = 64'h0F;   req1_cntrl = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL rr_grant[%0d]: ready=%b%b want %s", i, req0_ready,
                                  req1_ready, (i % 2 == 0) ? "10" : "01");
            end
            tick();
            n_vec++;
            if (resp_bus !== ((i % 2 == 0) ? {7'b1000101, 64'd0} : {7'b1100000, 64'hFF})) begin
                n_err++; $display("FAIL rr_resp[%0d]: got %h", i, resp_bus);
            end
        end
    endtask

    // Runs straight after test_round_robin: an XOR response from req1 is pending.
    task automatic test_stall();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_err++; $display("FAIL stall_ready[%0d]: ready=%b%b want 00", i, req0_ready, req1_ready);
            end
            tick();
            n_vec++;
            if (resp_bus !== {7'b1100000, 64'hFF}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, resp_bus, {7'b1100000, 64'hFF});
            end
        end
        resp_ready = 1'b1;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL stall_release: ready=%b%b want 10", req0_ready, req1_ready);
        end
        tick();
        n_vec++;
        if (resp_bus !== {7'b1000101, 64'd0}) begin
            n_err++; $display("FAIL stall_release_resp: got %h want %h", resp_bus, {7'b1000101, 64'd0});
        end
        idle_inputs();
    endtask

    task automatic test_illegal();
        do_reset();
        resp_ready = 1'b1;
        req1_valid = 1'b1; req1_A = 64'd1; req1_B = 64'd2; req1_cntrl = 3'b111;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL illegal_accept: ready=%b%b want 01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_vec++;
        if (resp_bus !== {7'b1110100, 64'd0}) begin
            n_err++; $display("FAIL illegal_resp: got %h want %h", resp_bus, {7'b1110100, 64'd0});
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 64'd1; req0_B = 64'd1; req0_cntrl = 3'b010;
        tick();
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL midflight_pending: resp_valid=%b want 1", resp_valid);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL midflight_async: resp_valid=%b want 0", resp_valid);
        end
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req1_cntrl = 3'b100;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL midflight_first_grant: ready=%b%b want 10", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_and_flag_mask();
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_cntrl = 3'b100;
        req0_A = 64'hFFFF_0000_FFFF_0000; req0_B = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        req0_valid = 1'b0;
        n_vec++;
        if (resp_bus !== {7'b1000000, 64'h0F0F_0000_0F0F_0000}) begin
            n_err++; $display("FAIL and_mask: got %h want %h", resp_bus, {7'b1000000, 64'h0F0F_0000_0F0F_0000});
        end
    endtask

    task automatic test_random();
        logic        v0, v1, pend0, pend1, m_lg, m_valid, can, g, w;
        logic [63:0] a0, b0, a1, b1;
        logic [2:0]  c0, c1;
        logic [70:0] m_resp;
        do_reset();
        m_lg = 1'b1; m_valid = 1'b0; m_resp = 71'd0;
        pend0 = 1'b0; pend1 = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = 64'd0; b0 = 64'd0; a1 = 64'd0; b1 = 64'd0; c0 = 3'd0; c1 = 3'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend0) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = pick_operand(); b0 = pick_operand(); c0 = 3'($urandom_range(0, 7));
            end
            if (!pend1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = pick_operand(); b1 = pick_operand(); c1 = 3'($urandom_range(0, 7));
            end
            req0_valid = v0; req0_A = a0; req0_B = b0; req0_cntrl = c0;
            req1_valid = v1; req1_A = a1; req1_B = b1; req1_cntrl = c1;
            resp_ready = ($urandom_range(0, 3) != 0);
            can = !m_valid || resp_ready;
            g   = v0 || v1;
            w   = (v0 && v1) ? !m_lg : v1;
            #1;
            n_vec++;
            if ({req0_ready, req1_ready} !== {can && g && !w, can && g && w}) begin
                n_err++; $display("FAIL rand_ready[%0d]: ready=%b%b want %b%b", cyc, req0_ready,
                                  req1_ready, can && g && !w, can && g && w);
            end
            n_vec++;
            if ({alu_A, alu_B, alu_cntrl} !== (!g ? 131'd0 : (w ? {a1, b1, c1} : {a0, b0, c0}))) begin
                n_err++; $display("FAIL rand_alu_drive[%0d]: A=%h B=%h cntrl=%b", cyc, alu_A, alu_B, alu_cntrl);
            end
            tick();
            if (can && g) begin
                m_valid = 1'b1;
                m_resp  = w ? ref_resp(1'b1, a1, b1, c1) : ref_resp(1'b0, a0, b0, c0);
                m_lg    = w;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
            pend0 = v0 && !(can && g && !w);
            pend1 = v1 && !(can && g && w);
            n_vec++;
            if (resp_valid !== m_valid) begin
                n_err++; $display("FAIL rand_resp_valid[%0d]: got %b want %b", cyc, resp_valid, m_valid);
            end
            if (m_valid) begin
                n_vec++;
                if (resp_bus !== m_resp) begin
                    n_err++; $display("FAIL rand_resp[%0d]: got %h want %h", cyc, resp_bus, m_resp);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_add_overflow();
        test_round_robin();
        test_stall();
        test_illegal();
        test_reset_midflight();
        test_and_flag_mask();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 64-bit ALU between two requesters: req0 is the execute stage, req1 is the address/branch unit.
- Each requester uses a valid/ready handshake to send an operation (A, B, cntrl).
- The arbiter grants one requester per cycle using round-robin, drives the shared ALU, and captures the result plus flags into a single response register.
- The response register is held until the consumer accepts it.

Parameters:
- WIDTH, 64, operand/result width (must match the ALU).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_A  in  WIDTH  operand A.
- req0_B  in  WIDTH  operand B.
- req0_cntrl  in  3  ALU op code.
- req1_valid, req1_ready, req1_A, req1_B, req1_cntrl: same as req0, for requester 1.
- alu_A  out  WIDTH  to shared ALU.
- alu_B  out  WIDTH  to shared ALU.
- alu_cntrl  out  3  to shared ALU.
- alu_result  in  WIDTH  from ALU.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the result (0/1).
- resp_result  out  WIDTH  captured result.
- resp_negative, resp_zero, resp_overflow, resp_carry_out  out  1 each  captured flags.
- resp_err  out  1  op code was illegal.

Behaviour:
- Op codes:
  - 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
  - 001 and 111 are illegal.
- Reset (async, immediate):
  - resp_valid=0, resp_id=0, resp_result=0, all resp flags=0, resp_err=0.
  - last_grant=1, so req0 wins the first contention.
  - An in-flight, unaccepted response is discarded.
- Slot free: can_issue = !resp_valid || resp_ready (same-cycle drain-and-refill allowed).
- Arbitration (combinational):
  - Only one requester valid: it wins.
  - Both valid: the requester != last_grant wins.
  - None valid: no grant.
- Handshake:
  - reqN_ready = can_issue && winner==N.
  - The loser's ready is 0. Loser's ready=0 and the winner's ready while !can_issue are combinational outputs; the requester holds its request until ready.
  - Ready does not depend on the requester's own valid beyond arbitration.
- ALU drive:
  - With a grant, alu_A/B/cntrl = the winner's fields.
  - With no grant, alu_A=0, alu_B=0, alu_cntrl=000.
  - The winner is still driven when !can_issue; harmless.
- Capture (rising edge when reqN_valid && reqN_ready):
  - resp_valid<=1, resp_id<=N, resp_result<=alu_result.
  - resp_negative<=alu_negative, resp_zero<=alu_zero.
  - resp_overflow/resp_carry_out <= alu flags only for 010/011, else 0.
  - last_grant<=N.
  - Latency: exactly 1 cycle from accept to resp_valid.
- Illegal op: still accepted and consumes one slot.
  - Captured with resp_err=1, resp_result=0.
  - resp_zero=1, resp_negative=0, resp_overflow=0, resp_carry_out=0.
- Drain: resp_valid && resp_ready with no new capture gives resp_valid<=0. Data fields may hold stale values.
- Hold: resp_valid && !resp_ready keeps all resp outputs stable; no req ready.
- last_grant changes only on an accepted transfer, so a stalled contention does not rotate priority.
- Throughput: one op per cycle when resp_ready is held high.

Test Plan:
- Reset then single req0 ADD, A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> req0_ready=1 that cycle. Next cycle: resp_valid=1, resp_id=0, resp_result=64'h8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
- Both valid every cycle, resp_ready=1, req0 SUB A=5 B=5, req1 XOR A=F0 B=0F -> grants alternate 0,1,0,1 starting with 0. The SUB response has zero=1, carry_out=1, overflow=0. The XOR response has result=FF, overflow=0, carry_out=0.
- resp_ready=0 for 3 cycles with a response pending and both requesters valid -> both readys=0, resp fields stable, last_grant unchanged. Raising resp_ready then gives the same-cycle accept of the correct round-robin winner.
- req1 cntrl=3'b111, A=1, B=2 -> accepted. Next cycle: resp_err=1, resp_result=0, zero=1, resp_id=1.
- Assert reset while resp_valid=1 and resp_ready=0 -> resp_valid drops immediately (before the next edge). After release, req0 wins the first contention.
- req0 AND with A=64'hFFFF_0000_FFFF_0000, B=64'h0F0F_0F0F_0F0F_0F0F, and the ALU model driving overflow=1, carry_out=1 -> resp_result=64'h0F0F_0000_0F0F_0000, resp_overflow=0, resp_carry_out=0.
